bcd_converter: RTL and testbench

Sequential binary-to-BCD converter sitting between the calculator ALU result register and the seven-segment digit decoders. It accepts a registered binary result on a start pulse and runs an iterative shift-add-3 (double-dabble) conversion, one input bit per clock. It then presents DIGITS packed BCD digits, a leading-zero blanking mask and an overflow flag, so the display shows decimal rather than hex.

---
 rtl/bcd_converter_if.sv | 24 ++
 rtl/bcd_converter.sv | 172 +++++++++++++++++
 tb/tb_bcd_converter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_converter_if.sv
// Handshake and result bundle between the ALU result register and the BCD converter.
interface bcd_converter_if #(
  parameter int BIN_WIDTH = 32,
  parameter int DIGITS    = 8
);
  logic                 start;
  logic [BIN_WIDTH-1:0] bin;
  logic                 busy;
  logic                 done;
  logic [4*DIGITS-1:0]  bcd;
  logic [DIGITS-1:0]    digit_en;
  logic                 overflow;
  logic                 neg;

  modport master (
    output start, bin,
    input  busy, done, bcd, digit_en, overflow, neg
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, digit_en, overflow, neg
  );
endinterface

// File: rtl/bcd_converter.sv
// Iterative shift-add-3 binary-to-BCD converter, one input bit per clock.
// Define BCD_CONV_SIGNED_EN to treat bin as two's complement and report the sign on neg.
module bcd_converter #(
  parameter int BIN_WIDTH = 32,
  parameter int DIGITS    = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  bcd_converter_if.slave bus
);

  localparam int DW = 4 * DIGITS;
  localparam int SW = DW + BIN_WIDTH;
  localparam int CW = $clog2(BIN_WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

  function automatic logic [DW-1:0] add3(input logic [DW-1:0] w);
    logic [DW-1:0] r;
    r = w;
    for (int i = 0; i < DIGITS; i++) begin
      if (w[4*i +: 4] >= 4'd5) r[4*i +: 4] = w[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Digit i is significant when it or any more-significant digit is nonzero.
  function automatic logic [DIGITS-1:0] sig_mask(input logic [DW-1:0] w);
    logic [DIGITS-1:0] m;
    logic              any;
    m   = '0;
    any = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      any  = any | (w[4*i +: 4] != 4'd0);
      m[i] = any;
    end
    m[0] = 1'b1;
    return m;
  endfunction

  logic [1:0]           state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BIN_WIDTH-1:0] shift_q, shift_d;
  logic [DW-1:0]        work_q, work_d;
  logic                 ovf_cap_q, ovf_cap_d;
  logic                 neg_cap_q, neg_cap_d;
  logic [DW-1:0]        bcd_q, bcd_d;
  logic [DIGITS-1:0]    den_q, den_d;
  logic                 ovf_q, ovf_d;
  logic                 neg_q, neg_d;

  logic [BIN_WIDTH-1:0] mag;
  logic                 mag_neg;
  logic                 mag_ovf;
  logic [SW-1:0]        shifted;

`ifdef BCD_CONV_SIGNED_EN
  // Negation is done at BIN_WIDTH bits unsigned so the most-negative value keeps its magnitude.
  assign mag_neg = bus.bin[BIN_WIDTH-1];
  assign mag     = mag_neg ? (~bus.bin + {{(BIN_WIDTH-1){1'b0}}, 1'b1}) : bus.bin;
`else
  assign mag_neg = 1'b0;
  assign mag     = bus.bin;
`endif

  assign mag_ovf = {{(64-BIN_WIDTH){1'b0}}, mag} > MAX_VAL;

  // Carry out of the top digit falls off the left, leaving magnitude mod 10^DIGITS.
  assign shifted = {add3(work_q), shift_q} << 1;

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    work_d    = work_q;
    ovf_cap_d = ovf_cap_q;
    neg_cap_d = neg_cap_q;
    bcd_d     = bcd_q;
    den_d     = den_q;
    ovf_d     = ovf_q;
    neg_d     = neg_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start) begin
          state_d   = S_CONV;
          busy_d    = 1'b1;
          cnt_d     = CW'(BIN_WIDTH);
          shift_d   = mag;
          work_d    = '0;
          ovf_cap_d = mag_ovf;
          neg_cap_d = mag_neg;
        end
      end
      S_CONV: begin
        if (cnt_q != '0) begin
          work_d  = shifted[SW-1:BIN_WIDTH];
          shift_d = shifted[BIN_WIDTH-1:0];
          cnt_d   = cnt_q - CW'(1);
        end else begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          bcd_d   = work_q;
          den_d   = ovf_cap_q ? {DIGITS{1'b1}} : sig_mask(work_q);
          ovf_d   = ovf_cap_q;
          neg_d   = neg_cap_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      den_q   <= {{(DIGITS-1){1'b0}}, 1'b1};
      ovf_q   <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      den_q   <= den_d;
      ovf_q   <= ovf_d;
      neg_q   <= neg_d;
    end
  end

  // Working datapath: always loaded at capture before use
  always_ff @(posedge clk) begin
    shift_q   <= shift_d;
    work_q    <= work_d;
    ovf_cap_q <= ovf_cap_d;
    neg_cap_q <= neg_cap_d;
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd      = bcd_q;
  assign bus.digit_en = den_q;
  assign bus.overflow = ovf_q;
`ifdef BCD_CONV_SIGNED_EN
  assign bus.neg      = neg_q;
`else
  assign bus.neg      = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_converter.sv
// Randomized bench for bcd_converter against an arithmetic reference model.
module tb_bcd_converter;
  localparam int BW = 32;
  localparam int ND = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bcd_converter_if #(.BIN_WIDTH(BW), .DIGITS(ND)) bus_if ();

  bcd_converter #(.BIN_WIDTH(BW), .DIGITS(ND)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference: decimal arithmetic on the magnitude.
  task automatic ref_conv(input logic [31:0] b, output logic [31:0] e_bcd,
                          output logic [7:0] e_en, output logic e_ovf, output logic e_neg);
    longint unsigned mag, v, p;
    bit neg;
`ifdef BCD_CONV_SIGNED_EN
    neg = b[31];
    mag = neg ? (64'h1_0000_0000 - {32'd0, b}) : {32'd0, b};
`else
    neg = 1'b0;
    mag = {32'd0, b};
`endif
    e_ovf = (mag > 64'd99999999);
    v     = mag % 64'd100000000;
    e_bcd = '0;
    p     = 1;
    for (int i = 0; i < ND; i++) begin
      e_en[i] = (i == 0) || ((v / p) != 0);
      p = p * 10;
    end
    for (int i = 0; i < ND; i++) begin
      e_bcd[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    if (e_ovf) e_en = 8'hFF;
    e_neg = neg;
  endtask

  int          remaining = 0;
  logic        m_busy = 0, m_done = 0, m_ovf = 0, m_neg = 0;
  logic [31:0] m_bcd = 0;
  logic [7:0]  m_en = 8'h01;
  logic [31:0] p_bcd = 0;
  logic [7:0]  p_en = 0;
  logic        p_ovf = 0, p_neg = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining = 0;
      m_busy = 0; m_done = 0; m_bcd = 0; m_en = 8'h01; m_ovf = 0; m_neg = 0;
    end else begin
      m_done = 0;
      if (remaining > 0) begin
        remaining--;
        if (remaining == 0) begin
          m_busy = 0; m_done = 1;
          m_bcd = p_bcd; m_en = p_en; m_ovf = p_ovf; m_neg = p_neg;
        end
      end else if (bus_if.start) begin
        remaining = BW + 1;
        m_busy = 1;
        ref_conv(bus_if.bin, p_bcd, p_en, p_ovf, p_neg);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("busy",     bus_if.busy,     m_busy);
      chk("done",     bus_if.done,     m_done);
      chk("bcd",      bus_if.bcd,      m_bcd);
      chk("digit_en", bus_if.digit_en, m_en);
      chk("overflow", bus_if.overflow, m_ovf);
      chk("neg",      bus_if.neg,      m_neg);
    end
  end

  task automatic start_conv(input logic [31:0] v);
    bus_if.start = 1'b1;
    bus_if.bin   = v;
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.bin   = $urandom;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus_if.done === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("done_seen", ok, 1);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] r;
    case ($urandom_range(0, 5))
      0: r = $urandom;
      1: r = $urandom_range(0, 999);
      2: r = 32'd99999996 + $urandom_range(0, 6);
      3: r = 32'd100000000 * $urandom_range(1, 42);
      4: r = 32'hFFFFFFFF - $urandom_range(0, 20);
      default: begin
        r = 32'd1;
        for (int k = $urandom_range(0, 9); k > 0; k--) r = r * 10;
      end
    endcase
    return r;
  endfunction

  initial begin
    logic [31:0] eb;
    logic [7:0]  ee;
    logic        eo, en;
    int          bc, dc;

    bus_if.start = 1'b0;
    bus_if.bin   = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", bus_if.busy, 0);
    chk("rst_done", bus_if.done, 0);
    chk("rst_bcd", bus_if.bcd, 0);
    chk("rst_digit_en", bus_if.digit_en, 8'h01);
    chk("rst_overflow", bus_if.overflow, 0);
    chk("rst_neg", bus_if.neg, 0);

    ref_conv(32'd12345678, eb, ee, eo, en);
    chk("ref_bcd_12345678", eb, 32'h12345678);
    chk("ref_en_12345678", ee, 8'hFF);
    ref_conv(32'd305, eb, ee, eo, en);
    chk("ref_bcd_305", eb, 32'h00000305);
    chk("ref_en_305", ee, 8'h07);
    ref_conv(32'd100000000, eb, ee, eo, en);
    chk("ref_ovf_1e8", eo, 1);
    chk("ref_bcd_1e8", eb, 32'h0);
    ref_conv(32'hFFFFFFFB, eb, ee, eo, en);
`ifdef BCD_CONV_SIGNED_EN
    chk("ref_bcd_m5", eb, 32'h5);
    chk("ref_neg_m5", en, 1);
`else
    chk("ref_bcd_fffffffb", eb, 32'h94967291);
    chk("ref_ovf_fffffffb", eo, 1);
`endif

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    start_conv(32'd0);
    wait_done();
    chk("t1_bcd", bus_if.bcd, 32'h0);
    chk("t1_digit_en", bus_if.digit_en, 8'h01);
    chk("t1_overflow", bus_if.overflow, 0);
    @(negedge clk);

    start_conv(32'h00BC614E);
    bc = 0;
    for (int i = 0; i < 60 && bus_if.done !== 1'b1; i++) begin
      if (bus_if.busy === 1'b1) bc++;
      @(negedge clk);
    end
    chk("t2_busy_cycles", bc, 33);
    chk("t2_bcd", bus_if.bcd, 32'h12345678);
    chk("t2_digit_en", bus_if.digit_en, 8'hFF);
    chk("t2_overflow", bus_if.overflow, 0);
    dc = 0;
    repeat (3) begin
      if (bus_if.done === 1'b1) dc++;
      @(negedge clk);
    end
    chk("t2_done_cycles", dc, 1);

    start_conv(32'd100000000);
    wait_done();
    chk("t3_overflow", bus_if.overflow, 1);
    chk("t3_bcd", bus_if.bcd, 32'h0);
    chk("t3_digit_en", bus_if.digit_en, 8'hFF);
    start_conv(32'd305);
    wait_done();
    chk("t3_b2b_bcd", bus_if.bcd, 32'h00000305);
    chk("t3_b2b_digit_en", bus_if.digit_en, 8'h07);
    chk("t3_b2b_overflow", bus_if.overflow, 0);
    @(negedge clk);

    start_conv(32'hFFFFFFFB);
    wait_done();
`ifdef BCD_CONV_SIGNED_EN
    chk("t4_neg", bus_if.neg, 1);
    chk("t4_bcd", bus_if.bcd, 32'h5);
    chk("t4_overflow", bus_if.overflow, 0);
`else
    chk("t4_neg", bus_if.neg, 0);
    chk("t4_bcd", bus_if.bcd, 32'h94967291);
    chk("t4_overflow", bus_if.overflow, 1);
`endif
    @(negedge clk);

    start_conv(32'd1234);
    repeat (9) @(negedge clk);
    start_conv(32'd99);
    wait_done();
    chk("t5_ignored_start_bcd", bus_if.bcd, 32'h00001234);
    chk("t5_digit_en", bus_if.digit_en, 8'h0F);
    @(negedge clk);
    start_conv(32'd5678);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", bus_if.busy, 0);
    chk("t5_rst_bcd", bus_if.bcd, 0);
    chk("t5_rst_digit_en", bus_if.digit_en, 8'h01);
    chk("t5_rst_overflow", bus_if.overflow, 0);
    repeat (3) begin
      @(negedge clk);
      chk("t5_no_done_in_rst", bus_if.done, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    start_conv(32'd42);
    wait_done();
    chk("t5_bcd_42", bus_if.bcd, 32'h00000042);
    chk("t5_digit_en_42", bus_if.digit_en, 8'h03);
    @(negedge clk);

    for (int c = 0; c < 6000; c++) begin
      bus_if.start = ($urandom_range(0, 3) == 0);
      bus_if.bin   = pick();
      @(negedge clk);
    end
    bus_if.start = 1'b0;
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
